// File: rtl/tree_pkg.sv
// Shared definitions for the tree walker: default widths, node word field layout, FSM encoding.
package tree_pkg;

  localparam int NODE_W_DEF = 198;
  localparam int ADDR_W_DEF = 3;

  // Node word layout at the default address width: {payload, leaf, child_1, child_2}
  localparam int CHILD2_LSB = 0;
  localparam int CHILD1_LSB = CHILD2_LSB + ADDR_W_DEF;
  localparam int LEAF_BIT   = CHILD1_LSB + ADDR_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/tree_walker_if.sv
// Node-word stream from the tree walker (master) to the PE-array scheduler (slave).
interface tree_walker_if #(
  parameter int NODE_W = tree_pkg::NODE_W_DEF,
  parameter int ADDR_W = tree_pkg::ADDR_W_DEF
);

  logic              valid;
  logic              ready;
  logic [NODE_W-1:0] node;
  logic [ADDR_W-1:0] addr;
  logic              leaf;
  logic              last;

  modport master (
    output valid,
    output node,
    output addr,
    output leaf,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  node,
    input  addr,
    input  leaf,
    input  last,
    output ready
  );

endinterface

// File: rtl/addr_lifo.sv
// LIFO of pending child_2 addresses; refuses pushes when full and pops when empty, never wraps.
module addr_lifo
  import tree_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top_addr,
  output logic              full,
  output logic              empty
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SP_W-1:0]   sp;
  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              do_push;
  logic              do_pop;

  assign full     = (sp == SP_W'(STACK_DEPTH));
  assign empty    = (sp == '0);
  assign do_push  = push && !full && !clear;
  assign do_pop   = pop && !empty && !clear;
  assign wr_idx   = IDX_W'(sp);
  assign rd_idx   = IDX_W'(sp - SP_W'(1));
  assign top_addr = mem[rd_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + SP_W'(1);
    end else if (do_pop) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Entries need no reset: only slots below sp are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_addr;
    end
  end

endmodule

// File: rtl/tree_walker.sv
// Depth-first pre-order walker over a node RAM; streams each node word once to the PE-array scheduler.
module tree_walker
  import tree_pkg::*;
#(
  parameter int NODE_W      = NODE_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STACK_DEPTH = 8,
  parameter int MAX_NODES   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] root_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [NODE_W-1:0] mem_rd_data,
  tree_walker_if.master     out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        node_count
);

  // Field offsets track ADDR_W; the package constants describe the default layout.
  localparam int C2_LSB = CHILD2_LSB;
  localparam int C1_LSB = CHILD1_LSB + (ADDR_W - ADDR_W_DEF);
  localparam int LEAF_B = LEAF_BIT + 2 * (ADDR_W - ADDR_W_DEF);
  localparam logic [8:0] MAX_CNT = 9'(MAX_NODES);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] cur_nxt;
  logic              push;
  logic              pop;
  logic              clear_walk;
  logic              capture;
  logic              accept;
  logic              set_err;
  logic              hit_limit;
  logic              lifo_full;
  logic              lifo_empty;
  logic [ADDR_W-1:0] lifo_top;

  addr_lifo #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_lifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_walk),
    .push      (push),
    .pop       (pop),
    .push_addr (out.node[C2_LSB +: ADDR_W]),
    .top_addr  (lifo_top),
    .full      (lifo_full),
    .empty     (lifo_empty)
  );

  assign hit_limit = (({1'b0, node_count} + 9'd1) == MAX_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur_addr;
    push       = 1'b0;
    pop        = 1'b0;
    clear_walk = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          clear_walk = 1'b1;
          cur_nxt    = root_addr;
          state_nxt  = ST_READ;
        end
      end
      ST_READ: state_nxt = ST_WAIT;
      ST_WAIT: begin
        capture   = 1'b1;
        state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (out.valid && out.ready) begin
          accept = 1'b1;
          // The node limit wins over every other exit so a looping tree always terminates.
          if (hit_limit && !out.last) begin
            set_err   = 1'b1;
            state_nxt = ST_DONE;
          end else if (!out.leaf && lifo_full) begin
            set_err   = 1'b1;
            state_nxt = ST_DONE;
          end else if (!out.leaf) begin
            push      = 1'b1;
            cur_nxt   = out.node[C1_LSB +: ADDR_W];
            state_nxt = ST_READ;
          end else if (!lifo_empty) begin
            pop       = 1'b1;
            cur_nxt   = lifo_top;
            state_nxt = ST_READ;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr    <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      out.valid   <= 1'b0;
      out.node    <= '0;
      out.addr    <= '0;
      out.leaf    <= 1'b0;
      out.last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      node_count  <= '0;
    end else begin
      cur_addr  <= cur_nxt;
      mem_rd_en <= (state_nxt == ST_READ);
      done      <= (state_nxt == ST_DONE);
      if (state_nxt == ST_READ) begin
        mem_rd_addr <= cur_nxt;
      end
      if (clear_walk) begin
        busy       <= 1'b1;
        err        <= 1'b0;
        node_count <= '0;
      end
      if (state == ST_DONE) begin
        busy <= 1'b0;
      end
      if (capture) begin
        out.valid <= 1'b1;
        out.node  <= mem_rd_data;
        out.addr  <= cur_addr;
        out.leaf  <= mem_rd_data[LEAF_B];
        out.last  <= mem_rd_data[LEAF_B] && lifo_empty;
      end
      if (accept) begin
        out.valid  <= 1'b0;
        node_count <= node_count + 8'd1;
      end
      if (set_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule
